// File: rtl/reg_arb_pkg.sv
// Shared types, default parameters and helpers for reg_write_arbiter.
// ARB_FIXED_PRIO_EN (see rr_pick) selects fixed-priority instead of round-robin arbitration.
package reg_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned NREQ_MAX  = 16;
  localparam int unsigned IDX_MAX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // One-hot vector at the widest supported requester count; callers truncate.
  function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    logic [NREQ_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection for reg_write_arbiter.
// Round-robin from ptr by default; ARB_FIXED_PRIO_EN selects lowest-index-wins and drops ptr.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [IDX_W-1:0] win_idx_c,
  output logic             any_req_c
);

`ifdef ARB_FIXED_PRIO_EN

  // First set bit from index 0 upward.
  always_comb begin
    win_idx_c = '0;
    any_req_c = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_req_c && req[IDX_W'(k)]) begin
        any_req_c = 1'b1;
        win_idx_c = IDX_W'(k);
      end
    end
  end

`else

  int unsigned cand;

  // First set bit at or after ptr, wrapping at NREQ-1; ptr is always below NREQ.
  always_comb begin
    win_idx_c = '0;
    any_req_c = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!any_req_c && req[IDX_W'(cand)]) begin
        any_req_c = 1'b1;
        win_idx_c = IDX_W'(cand);
      end
    end
  end

`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// Single write path into a shared WIDTH-bit register for NREQ requesters.
// Grant one requester per IDLE->WRITE pass; commit its data, owner tag and write count on the next edge.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDX_W-1:0]      q_owner,
  output logic                  q_valid,
  output logic [CNT_W-1:0]      wcount,
  output logic                  busy
);

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] win_idx_q;
  logic [IDX_W-1:0] win_idx_d;
  logic [NREQ-1:0]  gnt_d;
  logic [WIDTH-1:0] q_d;
  logic [IDX_W-1:0] q_owner_d;
  logic             q_valid_d;
  logic [CNT_W-1:0] wcount_d;
  logic             busy_d;

  logic [IDX_W-1:0] win_idx_c;
  logic             any_req_c;

  logic [WIDTH-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
  end

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req       (req),
`ifndef ARB_FIXED_PRIO_EN
    .ptr       (ptr_q),
`endif
    .win_idx_c (win_idx_c),
    .any_req_c (any_req_c)
  );

  // Next-state and next-output logic; gnt defaults low so it never spans two cycles.
  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    gnt_d     = '0;
    q_d       = q;
    q_owner_d = q_owner;
    q_valid_d = q_valid;
    wcount_d  = wcount;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d   = WRITE;
          win_idx_d = win_idx_c;
          gnt_d     = NREQ'(onehot(IDX_MAX_W'(win_idx_c)));
        end
      end
      WRITE: begin
        state_d = IDLE;
        // A winner that dropped req during its grant cycle aborts with no side effects.
        if (req[win_idx_q]) begin
          q_d       = wdata_a[win_idx_q];
          q_owner_d = win_idx_q;
          q_valid_d = 1'b1;
          wcount_d  = wcount + CNT_W'(1);
`ifndef ARB_FIXED_PRIO_EN
          ptr_d     = (32'(win_idx_q) == NREQ - 1) ? '0 : win_idx_q + IDX_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == WRITE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_idx_q <= '0;
      gnt       <= '0;
      q         <= '0;
      q_owner   <= '0;
      q_valid   <= 1'b0;
      wcount    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      gnt       <= gnt_d;
      q         <= q_d;
      q_owner   <= q_owner_d;
      q_valid   <= q_valid_d;
      wcount    <= wcount_d;
      busy      <= busy_d;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Grant is one-hot or idle, and always a single-cycle pulse.
  a_gnt_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt));
  a_gnt_pulse:   assert property (@(posedge clock) disable iff (!reset_n) (gnt != '0) |=> (gnt == '0));
  a_busy_state:  assert property (@(posedge clock) disable iff (!reset_n) busy == (state_q == WRITE));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed vectors push expected grant/commit results,
// a negedge monitor pops one entry per observed grant and checks the post-commit register state.
module tb_reg_write_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [1:0]            q_owner;
  logic                  q_valid;
  logic [CNT_W-1:0]      wcount;
  logic                  busy;

  typedef struct {
    logic [3:0] g;
    logic [7:0] qv;
    logic [1:0] o;
    logic       v;
    logic [3:0] wc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  reg_write_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .wcount  (wcount),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] qv, input logic [1:0] o,
                      input logic v, input logic [3:0] wc);
    exp_t e;
    e.g  = g;
    e.qv = qv;
    e.o  = o;
    e.v  = v;
    e.wc = wc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Raise one request, hold it through the grant cycle, drop it after the commit edge.
  task automatic write_one(input int idx, input logic [7:0] d);
    step();
    req = 4'b0001 << idx;
    wdata[idx*8 +: 8] = d;
    step();
    step();
    req = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && gnt !== 4'b0000) begin
        if (sb.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("gnt", 32'(gnt), 32'(e.g));
          chk("busy", 32'(busy), 32'd1);
          @(negedge clock);
          chk("gnt_release", 32'(gnt), 32'd0);
          chk("q", 32'(q), 32'(e.qv));
          chk("q_owner", 32'(q_owner), 32'(e.o));
          chk("q_valid", 32'(q_valid), 32'(e.v));
          chk("wcount", 32'(wcount), 32'(e.wc));
        end
      end
    end
  end

  initial begin : stim
    reset_n = 1'b0;
    req     = '0;
    wdata   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_q_owner", 32'(q_owner), 32'd0);
    chk("reset_q_valid", 32'(q_valid), 32'd0);
    chk("reset_wcount", 32'(wcount), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Reset asserted during the grant cycle: the write must not land.
    step();
    req         = 4'b0001;
    wdata[7:0]  = 8'hA5;
    push(4'b0001, 8'h00, 2'd0, 1'b0, 4'd0);
    @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_wcount", 32'(wcount), 32'd0);
    push(4'b0001, 8'hA5, 2'd0, 1'b1, 4'd1);
    step();
    reset_n = 1'b1;
    step();
    step();
    req = '0;

`ifdef ARB_FIXED_PRIO_EN
    // Lowest index always wins; 1 and 3 starve.
    wdata = 32'h4433_225F;
    for (int k = 0; k < 4; k++) push(4'b0001, 8'h5F, 2'd0, 1'b1, 4'(2 + k));
    step();
    req = 4'b1011;
    repeat (8) step();
    req = '0;
`else
    // Abort: requester 1 drops req during its grant cycle; ptr stays at 1.
    push(4'b0010, 8'hA5, 2'd0, 1'b1, 4'd1);
    step();
    req          = 4'b0010;
    wdata[15:8]  = 8'hEE;
    step();
    req = '0;
    step();

    // With ptr still at 1, index 1 beats index 0.
    push(4'b0010, 8'h77, 2'd1, 1'b1, 4'd2);
    step();
    req         = 4'b0011;
    wdata[7:0]  = 8'h66;
    wdata[15:8] = 8'h77;
    step();
    step();
    req = '0;

    push(4'b0100, 8'h3C, 2'd2, 1'b1, 4'd3);
    write_one(2, 8'h3C);
    push(4'b1000, 8'h5A, 2'd3, 1'b1, 4'd4);
    write_one(3, 8'h5A);

    // All four requesting from ptr=0: one commit per requester every 8 cycles, twice.
    wdata = 32'h4433_2211;
    for (int k = 0; k < 4; k++) push(4'(1 << k), 8'(8'h11 * (k + 1)), 2'(k), 1'b1, 4'(5 + k));
    for (int k = 0; k < 4; k++) push(4'(1 << k), 8'(8'h11 * (k + 1)), 2'(k), 1'b1, 4'(9 + k));
    step();
    req = 4'b1111;
    repeat (16) step();
    req = '0;

    push(4'b0001, 8'hC0, 2'd0, 1'b1, 4'd13);
    write_one(0, 8'hC0);
    push(4'b0010, 8'hC1, 2'd1, 1'b1, 4'd14);
    write_one(1, 8'hC1);
    push(4'b0100, 8'hC2, 2'd2, 1'b1, 4'd15);
    write_one(2, 8'hC2);

    // ptr=3 with req=1001: 3 first (wcount wraps to 0), then ptr wraps and 0 wins.
    wdata[31:24] = 8'hD3;
    wdata[7:0]   = 8'hD0;
    push(4'b1000, 8'hD3, 2'd3, 1'b1, 4'd0);
    push(4'b0001, 8'hD0, 2'd0, 1'b1, 4'd1);
    step();
    req = 4'b1001;
    repeat (4) step();
    req = '0;
`endif

    repeat (4) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
